diffsquare_tdm_pipe: RTL and testbench
======================================

# diffsquare_tdm_pipe

Parametrised, clocked successor to the combinational squared-difference pipe bank. Takes two vectors of WIDTH 32-bit two's-complement integers and returns WIDTH IEEE-754 single-precision values (a[i]−b[i])². It time-multiplexes LANES physical diffsquare datapaths over WIDTH/LANES beats. Valid/ready handshakes on both sides let it sit between the operand fetch stage and the distance-reduction stage.

## Interface
- WIDTH, 16, elements per vector.
- LANES, 4, physical subtract/convert/square datapaths. WIDTH must be a multiple of LANES; otherwise elaboration fails. BEATS = WIDTH/LANES.
- VARWIDTH (localparam), 32, element width.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand vectors present.
- in_ready  out  1  block can accept operands this cycle.
- vals0  in  VARWIDTH*WIDTH  minuend vector; element i at bits [32i+31:32i].
- vals1  in  VARWIDTH*WIDTH  subtrahend vector, same packing.
- out_valid  out  1  pipeout holds a complete result vector.
- out_ready  in  1  consumer accepts result.
- pipeout  out  VARWIDTH*WIDTH  float32 results, same packing as inputs.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states:
  - IDLE → RUN on accept.
  - RUN → DONE after the last result slot is written.
  - DONE → IDLE on out_ready && !in_valid.
  - DONE → RUN on out_ready && in_valid (back-to-back accept).
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept = in_valid && in_ready.
- On accept, vals0/vals1 are latched whole into the operand buffer. Inputs may change freely afterwards.
- RUN, issue stage:
  - Beat counter k runs 0..BEATS−1.
  - Each cycle, slice k (elements k*LANES .. k*LANES+LANES−1) is subtracted: diff = a + ~b + 1, mod 2³².
  - diff is registered into stage-1 together with tag k and a stage-1 valid bit.
- Stage 2: the stage-1 diff is interpreted as signed, converted to float32, squared (IEEE single), and written into result buffer slots tag*LANES.. on the next edge.
- Arithmetic:
  - Subtraction wraps; there is no saturation. Example: a=0x7FFFFFFF, b=0xFFFFFFFF gives diff 0x80000000 (−2³¹), which yields 0x5E800000.
  - Zero difference yields +0.0 (0x00000000).
- out_valid = (state==DONE). The result buffer, and hence pipeout, is stable while out_valid is high.
- busy = state≠IDLE.
- Reset, asynchronous, mid-operation:
  - State returns to IDLE; beat counter, stage-1 valid and stage-1 register clear to 0.
  - Result buffer clears to 0.
  - The in-flight vector is discarded. There is no partial output.
- Output values under reset: in_ready=1 (IDLE), out_valid=0, busy=0, pipeout=0.

## Timing
- Accept at edge E0; issue of beat k at edge E0+1+k; slot write at edge E0+2+k.
- out_valid rises after edge E0+BEATS+1. Latency from accept to out_valid is BEATS+1 cycles (5 for defaults).
- Throughput: one vector per BEATS+1 cycles when the consumer holds out_ready high (back-to-back accept in DONE).
- With out_ready low, DONE holds indefinitely, in_ready=0, and inputs are not sampled.
- Simultaneous out_ready && in_valid in DONE: the result is consumed and the new vector accepted on the same edge; out_valid drops for BEATS+1 cycles.
- LANES==WIDTH (BEATS=1): latency is 2 cycles; the counter is unused.

## Configuration
- DIFFSQ_ZERO_IDLE_EN defined: pipeout is forced to 0 whenever out_valid is low. This gates the result buffer on the output, matching the previous EN-low behaviour.
- DIFFSQ_ZERO_IDLE_EN undefined: pipeout always drives the result buffer. Partially updated slots are visible during RUN, and the last result stays visible in IDLE.
- Handshake and latency are identical in both builds.

## Test plan
- Reset check: apply reset, then release it → in_ready=1, out_valid=0, busy=0, pipeout=0.
- Basic vector (defaults, out_ready=1): all vals0[i]=3, vals1[i]=5 → out_valid 5 cycles after accept; every element 0x40800000; element 7 with vals0=10, vals1=0 → 0x42C80000.
- Boundary values: element 0: a=0x7FFFFFFF, b=0xFFFFFFFF → 0x5E800000. Element 1: a=b=7 → 0x00000000.
- Consumer stall: out_ready=0 for 10 cycles after out_valid → pipeout stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 with in_valid=1 → the second vector is accepted on the same edge and its result follows 5 cycles later.
- Mid-run reset: assert RST_N low at E0+2 → all outputs reach their reset values immediately. After release, a fresh vector completes correctly with no stale slots.
- Macro build comparison:
  - With DIFFSQ_ZERO_IDLE_EN: pipeout reads 0 throughout RUN.
  - Without it: slots 0–3 update one cycle before slots 4–7.
  - Run both builds with LANES=16 and confirm 2-cycle latency.

Source files
------------

// File: rtl/diffsquare_tdm_pipe.sv
// Time-multiplexed (a[i]-b[i])^2 pipe: LANES subtract/convert/square lanes over WIDTH/LANES beats.
// Optional macro DIFFSQ_ZERO_IDLE_EN forces pipeout to 0 whenever out_valid is low.
module diffsquare_tdm_pipe #(
   parameter  int WIDTH    = 16,
   parameter  int LANES    = 4,
   localparam int VARWIDTH = 32
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [VARWIDTH*WIDTH-1:0] vals0,
   input  logic [VARWIDTH*WIDTH-1:0] vals1,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [VARWIDTH*WIDTH-1:0] pipeout,
   output logic                      busy
);

   localparam int BEATS = WIDTH / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   if ((WIDTH % LANES) != 0) begin : g_bad_cfg
      $error("diffsquare_tdm_pipe: WIDTH must be a multiple of LANES");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e                             state_q, state_d;
   logic [CNT_W-1:0]                   beat_q, beat_d;
   logic                               s1_valid_q, s1_valid_d;
   logic [CNT_W-1:0]                   s1_tag_q, s1_tag_d;
   logic [LANES-1:0][VARWIDTH-1:0]     s1_diff_q, s1_diff_d;
   logic [VARWIDTH*WIDTH-1:0]          res_q, res_d;
   logic [VARWIDTH*WIDTH-1:0]          op_a_q, op_a_d, op_b_q, op_b_d;
   logic                               accept, last_written;

   // Signed int32 -> float32 magnitude (sign dropped: only the square is needed), round-to-nearest-even.
   function automatic logic [30:0] int_to_f32_mag(input logic [31:0] d);
      logic [31:0] mag, norm;
      logic [4:0]  msb;
      logic        round_up, carry;
      logic [22:0] mant;
      logic [7:0]  exp;
      mag = d[31] ? (~d + 32'd1) : d;
      msb = '0;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = 5'(i);
      norm = mag << (5'd31 - msb);
      round_up = norm[7] & (norm[8] | (|norm[6:0]));
      {carry, mant} = {1'b0, norm[30:8]} + 24'(round_up);
      exp = 8'd127 + {3'b000, msb} + {7'd0, carry};
      return norm[31] ? {exp, mant} : 31'd0;
   endfunction

   // IEEE single x*x for a positive normal or zero operand; the exponent range cannot overflow here.
   function automatic logic [31:0] f32_square(input logic [30:0] f);
      logic [23:0] sig;
      logic [47:0] p;
      logic [22:0] mant, mant_r;
      logic        hi, g, st, lsb, carry;
      logic [7:0]  exp;
      sig = {1'b1, f[22:0]};
      p   = sig * sig;
      hi  = p[47];
      if (hi) begin
         mant = p[46:24]; g = p[23]; st = |p[22:0]; lsb = p[24];
      end else begin
         mant = p[45:23]; g = p[22]; st = |p[21:0]; lsb = p[23];
      end
      {carry, mant_r} = {1'b0, mant} + 24'(g & (st | lsb));
      exp = 8'(({2'b00, f[30:23]} << 1) - 10'd127 + {9'd0, hi} + {9'd0, carry});
      return (f[30:23] == 8'd0) ? 32'd0 : {1'b0, exp, mant_r};
   endfunction

   assign in_ready     = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept       = in_valid && in_ready;
   assign out_valid    = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign last_written = s1_valid_q && (s1_tag_q == LAST_BEAT);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      state_d    = state_q;
      beat_d     = beat_q;
      s1_valid_d = 1'b0;
      s1_tag_d   = s1_tag_q;
      s1_diff_d  = s1_diff_q;
      res_d      = res_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;

      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last_written) state_d = DONE;
         DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         op_a_d = vals0;
         op_b_d = vals1;
         beat_d = '0;
      end

      // Issue stops once the last slice sits in stage 1; that same edge writes it and enters DONE.
      if ((state_q == RUN) && !last_written) begin
         for (int l = 0; l < LANES; l++) begin
            s1_diff_d[l] = op_a_q[(int'(beat_q)*LANES + l)*VARWIDTH +: VARWIDTH]
                         + ~op_b_q[(int'(beat_q)*LANES + l)*VARWIDTH +: VARWIDTH] + 32'd1;
         end
         s1_tag_d   = beat_q;
         s1_valid_d = 1'b1;
         beat_d     = (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_W'(1);
      end

      if (s1_valid_q) begin
         for (int l = 0; l < LANES; l++) begin
            res_d[(int'(s1_tag_q)*LANES + l)*VARWIDTH +: VARWIDTH] =
               f32_square(int_to_f32_mag(s1_diff_q[l]));
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         s1_valid_q <= 1'b0;
         s1_tag_q   <= '0;
         s1_diff_q  <= '0;
         res_q      <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         s1_valid_q <= s1_valid_d;
         s1_tag_q   <= s1_tag_d;
         s1_diff_q  <= s1_diff_d;
         res_q      <= res_d;
      end
   end

   // NOTE: the operand buffer is never read before an accept writes it, so it carries no reset.
   always_ff @(posedge CLK) begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
   end

`ifdef DIFFSQ_ZERO_IDLE_EN
   assign pipeout = out_valid ? res_q : '0;
`else
   assign pipeout = res_q;
`endif

endmodule

// File: tb/tb_diffsquare_tdm_pipe.sv
// Scoreboard bench for diffsquare_tdm_pipe: default LANES=4 instance plus a LANES=16 instance.
// Expected floats come from an exact-integer round-to-24-bits model, applied before and after squaring.
module tb_diffsquare_tdm_pipe;
   localparam int W = 16;
   localparam int N = 32 * W;
   typedef logic [N-1:0] vec_t;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid, busy;
   logic in_valid16 = 1'b0, out_ready16 = 1'b0, in_ready16, out_valid16, busy16;
   vec_t vals0 = '0, vals1 = '0, pipeout, pipeout16;

   int   checks = 0;
   int   failures = 0;
   vec_t sb[$];

   always #5 CLK = ~CLK;

   diffsquare_tdm_pipe #(.WIDTH(W), .LANES(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
      .vals0(vals0), .vals1(vals1), .out_valid(out_valid), .out_ready(out_ready),
      .pipeout(pipeout), .busy(busy));

   diffsquare_tdm_pipe #(.WIDTH(W), .LANES(16)) dut16 (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid16), .in_ready(in_ready16),
      .vals0(vals0), .vals1(vals1), .out_valid(out_valid16), .out_ready(out_ready16),
      .pipeout(pipeout16), .busy(busy16));

   function automatic int msb64(input logic [63:0] u);
      int p = -1;
      for (int i = 0; i < 64; i++) if (u[i]) p = i;
      return p;
   endfunction

   // Round a non-negative integer to 24 significant bits, nearest-even; result is still an integer.
   function automatic logic [63:0] round24(input logic [63:0] u);
      int p, s;
      logic [63:0] keep, rem, half;
      p = msb64(u);
      if (p <= 23) return u;
      s    = p - 23;
      keep = u >> s;
      rem  = u - (keep << s);
      half = 64'd1 << (s - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
      return keep << s;
   endfunction

   function automatic logic [31:0] pack32(input logic [63:0] v);
      int p;
      logic [63:0] m;
      logic [7:0]  e;
      p = msb64(v);
      if (p < 0) return 32'd0;
      m = (p >= 23) ? (v >> (p - 23)) : (v << (23 - p));
      e = 8'(127 + p);
      return {1'b0, e, m[22:0]};
   endfunction

   function automatic logic [31:0] model_elem(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      logic [63:0] mag, f;
      d   = a - b;
      mag = d[31] ? {32'd0, 32'd0 - d} : {32'd0, d};
      f   = round24(mag);
      return pack32(round24(f * f));
   endfunction

   function automatic vec_t model_vec(input vec_t a, input vec_t b);
      vec_t r;
      for (int i = 0; i < W; i++) r[i*32 +: 32] = model_elem(a[i*32 +: 32], b[i*32 +: 32]);
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t r;
      for (int i = 0; i < W; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string tag, input vec_t obs, input vec_t exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_compare(input string tag, input vec_t obs, output vec_t e);
      check({tag, "_sb_nonempty"}, vec_t'(sb.size() != 0), vec_t'(1));
      e = '0;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check(tag, obs, e);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_valid(inout int lat);
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   initial begin
      vec_t va, vb, ea, eb, ec, ef, eg;
      int   lat;

      // Reset
      repeat (3) step();
      RST_N = 1'b1;
      step();
      check("rst_in_ready", vec_t'(in_ready), vec_t'(1));
      check("rst_out_valid", vec_t'(out_valid), vec_t'(0));
      check("rst_busy", vec_t'(busy), vec_t'(0));
      check("rst_pipeout", pipeout, '0);
      check("rst16_in_ready", vec_t'(in_ready16), vec_t'(1));
      check("rst16_pipeout", pipeout16, '0);

      // Vector A: all 3-5, element 7 is 10-0
      for (int i = 0; i < W; i++) begin
         va[i*32 +: 32] = 32'd3;
         vb[i*32 +: 32] = 32'd5;
      end
      va[7*32 +: 32] = 32'd10;
      vb[7*32 +: 32] = 32'd0;
      vals0 = va; vals1 = vb; in_valid = 1'b1; out_ready = 1'b1;
      step();
      sb.push_back(model_vec(va, vb));
      ea = model_vec(va, vb);
      in_valid = 1'b0;
      check("a_busy", vec_t'(busy), vec_t'(1));
      check("a_in_ready_run", vec_t'(in_ready), vec_t'(0));
      check("a_out_valid_run", vec_t'(out_valid), vec_t'(0));
      step();
      check("a_run_e1", pipeout, '0);
      step();
`ifdef DIFFSQ_ZERO_IDLE_EN
      check("a_run_e2_zero", pipeout, '0);
`else
      check("a_run_e2_slots0_3", vec_t'(pipeout[127:0]), vec_t'(ea[127:0]));
      check("a_run_e2_slots4_7", vec_t'(pipeout[255:128]), '0);
`endif
      step();
`ifdef DIFFSQ_ZERO_IDLE_EN
      check("a_run_e3_zero", pipeout, '0);
`else
      check("a_run_e3_slots0_7", vec_t'(pipeout[255:0]), vec_t'(ea[255:0]));
`endif
      lat = 3;
      wait_valid(lat);
      check("a_latency", vec_t'(lat), vec_t'(5));
      pop_compare("a_result", pipeout, ea);
      check("a_elem3", vec_t'(pipeout[3*32 +: 32]), vec_t'(32'h40800000));
      check("a_elem7", vec_t'(pipeout[7*32 +: 32]), vec_t'(32'h42C80000));
      step();
      check("a_idle_out_valid", vec_t'(out_valid), vec_t'(0));
      check("a_idle_busy", vec_t'(busy), vec_t'(0));
`ifdef DIFFSQ_ZERO_IDLE_EN
      check("a_idle_pipeout", pipeout, '0);
`else
      check("a_idle_pipeout", pipeout, ea);
`endif

      // Vector B: wrap boundary, zero difference, random rest; consumer stalls
      va = rand_vec(); vb = rand_vec();
      va[0 +: 32] = 32'h7FFFFFFF; vb[0 +: 32] = 32'hFFFFFFFF;
      va[32 +: 32] = 32'd7;       vb[32 +: 32] = 32'd7;
      vals0 = va; vals1 = vb; in_valid = 1'b1; out_ready = 1'b0;
      step();
      sb.push_back(model_vec(va, vb));
      in_valid = 1'b0;
      lat = 0;
      wait_valid(lat);
      check("b_latency", vec_t'(lat), vec_t'(5));
      pop_compare("b_result", pipeout, eb);
      check("b_elem0_wrap", vec_t'(pipeout[0 +: 32]), vec_t'(32'h5E800000));
      check("b_elem1_zero", vec_t'(pipeout[32 +: 32]), '0);
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         vals0 = rand_vec(); vals1 = rand_vec();
         step();
         check("stall_pipeout", pipeout, eb);
         check("stall_in_ready", vec_t'(in_ready), vec_t'(0));
         check("stall_out_valid", vec_t'(out_valid), vec_t'(1));
      end

      // Vector C accepted on the same edge that consumes B
      va = rand_vec(); vb = rand_vec();
      vals0 = va; vals1 = vb; out_ready = 1'b1;
      #1;
      check("done_in_ready", vec_t'(in_ready), vec_t'(1));
      step();
      sb.push_back(model_vec(va, vb));
      in_valid = 1'b0;
      check("c_out_valid_drop", vec_t'(out_valid), vec_t'(0));
      check("c_busy", vec_t'(busy), vec_t'(1));
      lat = 0;
      wait_valid(lat);
      check("c_latency", vec_t'(lat), vec_t'(5));
      pop_compare("c_result", pipeout, ec);
      step();

      // Mid-run reset discards the in-flight vector
      va = rand_vec(); vb = rand_vec();
      vals0 = va; vals1 = vb; in_valid = 1'b1;
      step();
      sb.push_back(model_vec(va, vb));
      in_valid = 1'b0;
      step();
      step();
      RST_N = 1'b0;
      #1;
      check("mrst_in_ready", vec_t'(in_ready), vec_t'(1));
      check("mrst_out_valid", vec_t'(out_valid), vec_t'(0));
      check("mrst_busy", vec_t'(busy), vec_t'(0));
      check("mrst_pipeout", pipeout, '0);
      sb.delete();
      #2;
      RST_N = 1'b1;
      step();
      va = rand_vec(); vb = rand_vec();
      vals0 = va; vals1 = vb; in_valid = 1'b1;
      step();
      sb.push_back(model_vec(va, vb));
      in_valid = 1'b0;
      lat = 0;
      wait_valid(lat);
      check("f_latency", vec_t'(lat), vec_t'(5));
      pop_compare("f_result", pipeout, ef);
      step();

      // LANES == WIDTH instance: two-cycle latency
      va = rand_vec(); vb = rand_vec();
      vals0 = va; vals1 = vb; in_valid16 = 1'b1; out_ready16 = 1'b1;
      step();
      sb.push_back(model_vec(va, vb));
      in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < 40) begin
         step();
         lat++;
      end
      check("l16_latency", vec_t'(lat), vec_t'(2));
      pop_compare("l16_result", pipeout16, eg);
      step();
      check("l16_idle_busy", vec_t'(busy16), vec_t'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
